// File: rtl/exec_sequencer_if.sv
// Front-panel / CPU control bundle for exec_sequencer.
// slave  : sequencer side. It takes the panel controls and the CPU status and drives
//          the CPU gating signals and the debug status.
// master : the panel and the CPU model side, which is the opposite direction.
interface exec_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic             stop;
    logic             step_cycle;
    logic             step_instr;
    logic             reset_req;
    logic             bp_en;
    logic [15:0]      bp_addr;
    logic             rt;
    logic [15:0]      pc_val;
    logic             cpu_en;
    logic             cpu_rst_bar;
    logic             running;
    logic             bp_hit;
    logic [CNT_W-1:0] cyc_count;
    logic [CNT_W-1:0] ins_count;

    modport slave (
        input  run, stop, step_cycle, step_instr, reset_req, bp_en, bp_addr, rt, pc_val,
        output cpu_en, cpu_rst_bar, running, bp_hit, cyc_count, ins_count
    );

    modport master (
        output run, stop, step_cycle, step_instr, reset_req, bp_en, bp_addr, rt, pc_val,
        input  cpu_en, cpu_rst_bar, running, bp_hit, cyc_count, ins_count
    );
endinterface

// File: rtl/exec_sequencer.sv
// Run/halt/single-step controller for the CPU. It gates CPU progress with a clock enable
// and owns the CPU reset line. It stops at instruction boundaries (the RT bit) or on a
// PC breakpoint, and it keeps cycle and instruction counters for the debug display.
// Ports:
//   clk  : system clock
//   RST  : synchronous, active-high reset
//   sq   : exec_sequencer_if.slave. Inputs are run/stop/step_cycle/step_instr/reset_req,
//          bp_en/bp_addr, rt and pc_val. Outputs are cpu_en, cpu_rst_bar, running,
//          bp_hit, cyc_count and ins_count.
module exec_sequencer #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                clk,
    input  logic                RST,
    exec_sequencer_if.slave     sq
);
    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_HALTED,
        S_RUNNING,
        S_STEP_C,
        S_STEP_I
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              at_start;
    logic              skip_bp;
    logic              stop_pend;
    logic              bp_hit;
    logic [CNT_W-1:0]  cyc_count;
    logic [CNT_W-1:0]  ins_count;

    logic bp_stop;
    logic cpu_en;
    logic cpu_rst_bar;
    logic adv;
    logic boundary;

    // A breakpoint freezes the CPU in the same cycle, at T0 of the matching fetch.
    assign bp_stop     = (state == S_RUNNING) && at_start && !skip_bp && sq.bp_en
                         && (sq.pc_val == sq.bp_addr);
    assign cpu_en      = (state != S_HALTED) && !bp_stop;
    assign cpu_rst_bar = (state != S_RST_HOLD);
    assign adv         = cpu_en && cpu_rst_bar;
    assign boundary    = adv && sq.rt;

    assign sq.cpu_en      = cpu_en;
    assign sq.cpu_rst_bar = cpu_rst_bar;
    assign sq.running     = (state == S_RUNNING) || (state == S_STEP_I) || (state == S_STEP_C);
    assign sq.bp_hit      = bp_hit;
    assign sq.cyc_count   = cyc_count;
    assign sq.ins_count   = ins_count;

    // Sequencer state, counters and flags.
    always_ff @(posedge clk) begin
        if (RST || sq.reset_req) begin
            state     <= S_RST_HOLD;
            hold_cnt  <= HOLD_W'(RESET_CYCLES - 1);
            at_start  <= 1'b1;
            skip_bp   <= 1'b0;
            stop_pend <= 1'b0;
            bp_hit    <= 1'b0;
            cyc_count <= '0;
            ins_count <= '0;
        end else begin
            if (adv)      cyc_count <= cyc_count + CNT_W'(1);
            if (boundary) ins_count <= ins_count + CNT_W'(1);
            if (boundary)   at_start <= 1'b1;
            else if (adv)   at_start <= 1'b0;
            if (adv)        skip_bp  <= 1'b0;

            case (state)
                S_RST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state    <= S_HALTED;
                        at_start <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                S_HALTED: begin
                    // stop is meaningless while halted, so step/run still take effect.
                    if (sq.step_instr) begin
                        state  <= S_STEP_I;
                        bp_hit <= 1'b0;
                    end else if (sq.step_cycle) begin
                        state  <= S_STEP_C;
                        bp_hit <= 1'b0;
                    end else if (sq.run) begin
                        state     <= S_RUNNING;
                        bp_hit    <= 1'b0;
                        skip_bp   <= bp_hit;   // resume off the breakpoint PC
                        stop_pend <= 1'b0;
                    end
                end
                S_STEP_C: state <= S_HALTED;
                S_STEP_I: begin
                    if (boundary) state <= S_HALTED;
                end
                S_RUNNING: begin
                    if (bp_stop) begin
                        state  <= S_HALTED;
                        bp_hit <= 1'b1;
                    end else if (boundary && (sq.stop || stop_pend)) begin
                        state     <= S_HALTED;
                        stop_pend <= 1'b0;
                    end else if (sq.stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: state <= S_RST_HOLD;
            endcase
        end
    end
endmodule
